ppp_block_sequencer: RTL

PPP_BLOCK_SEQUENCER -- requirements
Module: ppp_block_sequencer

---
 rtl/ppp_block_sequencer_pkg.sv | 15 +
 rtl/ppp_block_sequencer_count_alarm.sv | 33 +++
 rtl/ppp_block_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ppp_block_sequencer_pkg.sv
// Shared parameters and state encoding for the PosMap PLB block sequencer.
package ppp_block_sequencer_pkg;

   localparam int PPP_LEAF_WIDTH    = 32;
   localparam int PPP_LEAF_IN_BLOCK = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EV_WAIT  = 3'd1,
      EV_READ  = 3'd2,
      EV_DRAIN = 3'd3,
      RF_WRITE = 3'd4
   } seq_state_t;

endpackage

// File: rtl/ppp_block_sequencer_count_alarm.sv
// Leaf index counter: counts enabled cycles modulo Threshold and flags the last one.
module ppp_block_sequencer_count_alarm #(
   parameter int Threshold  = 8,
   parameter int CountWidth = $clog2(Threshold)
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Clear,
   input  logic                  Enable,
   output logic [CountWidth-1:0] Count,
   output logic                  Done
);

   assign Done = Enable && (Count == CountWidth'(Threshold - 1));

   // Index register: cleared by reset or Clear, wraps after the Threshold-th step.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         Count <= '0;
      end else if (Clear) begin
         Count <= '0;
      end else if (Enable) begin
         if (Done) begin
            Count <= '0;
         end else begin
            Count <= Count + {{(CountWidth-1){1'b0}}, 1'b1};
         end
      end else begin
         Count <= Count;
      end
   end

endmodule

// File: rtl/ppp_block_sequencer.sv
// Moves one PosMap block between a PLB line and the UORAM datapath: evict
// reads a line out as a gap-free burst, refill writes a streamed line back.
module ppp_block_sequencer
   import ppp_block_sequencer_pkg::*;
#(
   parameter int LeafWidth   = PPP_LEAF_WIDTH,
   parameter int LeafInBlock = PPP_LEAF_IN_BLOCK,
   parameter int SlotWidth   = 4
) (
   input  logic                                     Clock,
   input  logic                                     Reset,
   input  logic                                     EvictCmdValid,
   output logic                                     EvictCmdReady,
   input  logic [SlotWidth-1:0]                     EvictSlot,
   input  logic                                     RefillCmdValid,
   output logic                                     RefillCmdReady,
   input  logic [SlotWidth-1:0]                     RefillSlot,
   output logic [SlotWidth+$clog2(LeafInBlock)-1:0] RAMAddr,
   output logic                                     RAMRdEn,
   input  logic [LeafWidth-1:0]                     RAMRdData,
   output logic                                     RAMWrEn,
   output logic [LeafWidth-1:0]                     RAMWrData,
   input  logic                                     PPPEvictDataEmpty,
   output logic                                     PPPEvictDataValid,
   output logic [LeafWidth-1:0]                     PPPEvictData,
   input  logic                                     PPPRefillDataValid,
   output logic                                     PPPRefillDataReady,
   input  logic [LeafWidth-1:0]                     PPPRefillData,
   output logic                                     Busy,
   output logic                                     EvictDone,
   output logic                                     RefillDone
);

   localparam int IdxWidth = $clog2(LeafInBlock);

   seq_state_t           state;
   logic [SlotWidth-1:0] slot;
   logic [IdxWidth-1:0]  idx;
   logic                 idx_done;
   logic                 rd_valid;
   logic                 evict_fire;
   logic                 refill_fire;
   logic                 refill_hs;
   logic                 count_en;

   // Evict wins a tie, so refill is only offered when no evict is pending.
   assign evict_fire  = (state == IDLE) && EvictCmdValid;
   assign refill_fire = (state == IDLE) && RefillCmdValid && !EvictCmdValid;
   assign refill_hs   = (state == RF_WRITE) && PPPRefillDataValid;
   assign count_en    = (state == EV_READ) || refill_hs;

   ppp_block_sequencer_count_alarm #(
      .Threshold (LeafInBlock)
   ) u_idx (
      .Clock  (Clock),
      .Reset  (Reset),
      .Clear  (state == IDLE),
      .Enable (count_en),
      .Count  (idx),
      .Done   (idx_done)
   );

   assign EvictCmdReady      = (state == IDLE);
   assign RefillCmdReady     = (state == IDLE) && !EvictCmdValid;
   assign Busy               = (state != IDLE);
   assign EvictDone          = (state == EV_DRAIN);
   assign RefillDone         = refill_hs && idx_done;
   assign RAMAddr            = {slot, idx};
   assign RAMRdEn            = (state == EV_READ);
   assign RAMWrEn            = refill_hs;
   assign RAMWrData          = refill_hs ? PPPRefillData : {LeafWidth{1'b0}};
   assign PPPRefillDataReady = (state == RF_WRITE);
   assign PPPEvictDataValid  = rd_valid;
   assign PPPEvictData       = rd_valid ? RAMRdData : {LeafWidth{1'b0}};

   // Sequencer state, latched slot and the read-valid delay matching RAM latency.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state    <= IDLE;
         slot     <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= (state == EV_READ);
         case (state)
            IDLE: begin
               if (evict_fire) begin
                  slot  <= EvictSlot;
                  state <= EV_WAIT;
               end else if (refill_fire) begin
                  slot  <= RefillSlot;
                  state <= RF_WRITE;
               end else begin
                  state <= IDLE;
               end
            end
            EV_WAIT: begin
               if (PPPEvictDataEmpty) begin
                  state <= EV_READ;
               end else begin
                  state <= EV_WAIT;
               end
            end
            EV_READ: begin
               if (idx_done) begin
                  state <= EV_DRAIN;
               end else begin
                  state <= EV_READ;
               end
            end
            EV_DRAIN: begin
               state <= IDLE;
            end
            RF_WRITE: begin
               if (refill_hs && idx_done) begin
                  state <= IDLE;
               end else begin
                  state <= RF_WRITE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
